// File: rtl/gpio_ctrl.sv
// GPIO controller: synchronized pad inputs, output/direction registers and a
// per-pin edge/level interrupt unit behind a single-cycle-ack register bus.
module gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [WIDTH-1:0] o_wb_rdt,
  output logic             o_wb_ack,
  output logic             intr
);

  localparam logic [2:0] A_DIN   = 3'd0;
  localparam logic [2:0] A_DOUT  = 3'd1;
  localparam logic [2:0] A_DIR   = 3'd2;
  localparam logic [2:0] A_IE    = 3'd3;
  localparam logic [2:0] A_ITYPE = 3'd4;
  localparam logic [2:0] A_IPOL  = 3'd5;
  localparam logic [2:0] A_ISTAT = 3'd6;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] din, prev_q;
  logic [WIDTH-1:0] dout_q, dir_q, ie_q, itype_q, ipol_q, istat_q;
  logic [WIDTH-1:0] evt, clr, rd_data;
  logic             access, wr;

  assign din     = sync_q[SYNC_STAGES-1];
  assign gpio_o  = dout_q;
  assign gpio_oe = dir_q;
  assign access  = i_wb_cyc & ~o_wb_ack;
  assign wr      = access & i_wb_we;
  assign clr     = (wr && addr == A_ISTAT) ? i_wb_dat : '0;

  // Input synchronizer and previous-value register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= din;
    end
  end

  // Output-driven pins never raise events; level mode fires while din matches IPOL
  always_comb begin
    evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!dir_q[i]) begin
        if (itype_q[i])
          evt[i] = ipol_q[i] ? (din[i] & ~prev_q[i]) : (~din[i] & prev_q[i]);
        else
          evt[i] = (din[i] == ipol_q[i]);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      A_DIN:   rd_data = din;
      A_DOUT:  rd_data = dout_q;
      A_DIR:   rd_data = dir_q;
      A_IE:    rd_data = ie_q;
      A_ITYPE: rd_data = itype_q;
      A_IPOL:  rd_data = ipol_q;
      A_ISTAT: rd_data = istat_q;
      default: rd_data = '0;
    endcase
  end

  // Bus access: one-cycle ack, write commit and read capture on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      dout_q   <= '0;
      dir_q    <= '0;
      ie_q     <= '0;
      itype_q  <= '1;
      ipol_q   <= '0;
    end else begin
      o_wb_ack <= access;
      if (access) o_wb_rdt <= rd_data;
      if (wr) begin
        case (addr)
          A_DOUT:  dout_q  <= i_wb_dat;
          A_DIR:   dir_q   <= i_wb_dat;
          A_IE:    ie_q    <= i_wb_dat;
          A_ITYPE: itype_q <= i_wb_dat;
          A_IPOL:  ipol_q  <= i_wb_dat;
          default: ;
        endcase
      end
    end
  end

  // Interrupt status: a same-edge event overrides a write-1-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      istat_q <= '0;
      intr    <= 1'b0;
    end else begin
      istat_q <= (istat_q & ~clr) | evt;
      intr    <= |(istat_q & ie_q);
    end
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of GPIO pins and data width, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..4.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port gpio_i, input, WIDTH: pad input values, asynchronous to clk.
REQ-006 SHALL have port gpio_o, output, WIDTH: pad output values.
REQ-007 SHALL have port gpio_oe, output, WIDTH: pad output enable, 1 = drive.
REQ-008 SHALL have port addr, input, 3: register word address.
REQ-009 SHALL have port i_wb_dat, input, WIDTH: write data.
REQ-010 SHALL have port i_wb_we, input, 1: write enable.
REQ-011 SHALL have port i_wb_cyc, input, 1: bus cycle request.
REQ-012 SHALL have port o_wb_rdt, output, WIDTH: registered read data.
REQ-013 SHALL have port o_wb_ack, output, 1: access acknowledge.
REQ-014 SHALL have port int, output, 1: registered interrupt request.

Function
REQ-015 SHALL implement this register map: 0 DIN (read-only), 1 DOUT, 2 DIR (1 = output), 3 IE, 4 ITYPE (1 = edge, 0 = level), 5 IPOL (1 = rising/high, 0 = falling/low), 6 ISTAT (read / write-1-to-clear), 7 reserved.
REQ-016 SHALL drive gpio_o = DOUT and gpio_oe = DIR combinationally from the registers.
REQ-017 SHALL pass each gpio_i bit through SYNC_STAGES flops; DIN = last synchronizer stage for all pins, including outputs.
REQ-018 SHALL assert o_wb_ack at the edge where i_wb_cyc=1 and o_wb_ack=0, and deassert it on the following edge, giving a one-cycle pulse and at most one access per two cycles.
REQ-019 SHALL commit writes and load o_wb_rdt with the addressed register at the same edge that asserts ack; o_wb_rdt SHALL hold its value otherwise.
REQ-020 SHALL ignore writes to addr 0 and 7; reads of addr 7 SHALL return 0.
REQ-021 SHALL hold a prev register of the synchronized inputs, updated every cycle regardless of DIR.
REQ-022 SHALL compute an event for bit i only when DIR[i]=0: edge mode fires on sync&~prev (IPOL=1) or ~sync&prev (IPOL=0); level mode fires while sync==IPOL.
REQ-023 SHALL set ISTAT[i] on any event regardless of IE; it stays set until cleared.
REQ-024 SHALL clear an ISTAT bit on a write of 1 to addr 6; if an event occurs on the same edge, set SHALL win.
REQ-025 SHALL register int = |(ISTAT & IE), one cycle after ISTAT changes.
REQ-026 SHALL set ISTAT one cycle after the end of the synchronizer, i.e., after edge k+SYNC_STAGES for a pin change stable before edge k, with int following one edge later.
REQ-027 SHALL generate an event, when IPOL/ITYPE/DIR are written, only from the new configuration starting the next cycle; no retroactive event is generated.

Reset
REQ-028 SHALL, on rst=1 and independent of clk, force DOUT=0, DIR=0, IE=0, ITYPE=all ones, IPOL=0, ISTAT=0, synchronizer and prev=0, o_wb_ack=0, o_wb_rdt=0, int=0.
REQ-029 SHALL abandon an access in progress when reset is asserted mid-access, with no partial write; ack SHALL restart only after rst falls and i_wb_cyc is sampled high.

Verification
REQ-030 SHALL be verified by a reset scenario: release rst, then read each addr 0..7 -> 0, 0, 0, 0, 0xFF, 0, 0, 0 (WIDTH=8) and gpio_oe=0.
REQ-031 SHALL be verified by an output scenario: write DIR=0x0F, then DOUT=0xA5 -> gpio_oe=0x0F and gpio_o=0xA5 after the ack edge; a DOUT read returns 0xA5.
REQ-032 SHALL be verified by a falling-edge scenario: IE=0x01, gpio_i[0] 1->0 -> ISTAT=0x01 at k+2 and int=1 at k+3; write 0x01 to addr 6 -> ISTAT=0 and int drops one cycle later.
REQ-033 SHALL be verified by a level-high scenario: ITYPE[3]=0, IPOL[3]=1, hold gpio_i[3]=1, W1C ISTAT -> bit 3 reads 1 again (set wins).
REQ-034 SHALL be verified by a masking scenario: DIR[2]=1 with gpio_i[2] toggling -> ISTAT[2] stays 0; IE=0 with an event -> ISTAT bit set and int=0.
REQ-035 SHALL be verified by a back-to-back scenario: hold i_wb_cyc=1 for 6 cycles -> ack pattern 1,0,1,0,1,0 with three writes committed.
